// File: rtl/por_sequencer.sv
// por_sequencer: schedules power-on-reset pulses for two redundant units.
// A health fall on an unlocked unit marks it pending. An idle sequencer grants
// one pending unit, holds its POR for a fixed pulse, and then waits a bounded
// time for health to return. Failed recoveries are counted per unit, and a unit
// is locked out once the count reaches the limit. Only one unit is in service
// at a time, so por can never be 11.
module por_sequencer #(
  parameter int POR_PULSE        = 50000000,
  parameter int RECOVERY_TIMEOUT = 250000000,
  parameter int MAX_RETRIES      = 3,
  parameter int CNT_W            = 29
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] health,
  input  logic [1:0] prime,
  input  logic [1:0] clr_lockout,
  output logic [1:0] por,
  output logic [1:0] lockout,
  output logic [1:0] retry_cnt0,
  output logic [1:0] retry_cnt1,
  output logic       busy,
  output logic       sel
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ASSERT = 2'd1,
    WAIT   = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] POR_LAST  = CNT_W'(POR_PULSE - 1);
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(RECOVERY_TIMEOUT - 1);
  localparam logic [1:0]       MAX_R     = 2'(MAX_RETRIES);

  state_t           state_q, state_d;
  logic [1:0]       por_q, por_d;
  logic [1:0]       lockout_q, lockout_d;
  logic [1:0][1:0]  retry_q, retry_d;
  logic             busy_q, busy_d;
  logic             sel_q, sel_d;
  logic             rr_q, rr_d;
  logic [1:0]       pending_q, pending_d;
  logic [1:0]       health_dly_q, health_dly_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [1:0]       fall;
  logic             grant;
  logic [1:0]       retry_next;

  // Next-state logic: fall detection, arbitration, pulse and recovery timing.
  always_comb begin
    state_d      = state_q;
    por_d        = por_q;
    lockout_d    = lockout_q;
    retry_d      = retry_q;
    sel_d        = sel_q;
    rr_d         = rr_q;
    cnt_d        = cnt_q;
    pending_d    = pending_q;
    health_dly_d = health;

    fall = health_dly_q & ~health;

    // A single pending unit wins outright. With both pending, the non-prime
    // unit goes first. When prime cannot decide, the round-robin pointer does.
    if (pending_q == 2'b01) begin
      grant = 1'b0;
    end else if (pending_q == 2'b10) begin
      grant = 1'b1;
    end else if (prime[0] != prime[1]) begin
      grant = prime[0];
    end else begin
      grant = ~rr_q;
    end

    retry_next = (retry_q[sel_q] == MAX_R) ? MAX_R : retry_q[sel_q] + 2'd1;

    for (int i = 0; i < 2; i++) begin
      if (fall[i] && !lockout_q[i] && !(state_q != IDLE && sel_q == 1'(i))) begin
        pending_d[i] = 1'b1;
      end
    end

    case (state_q)
      IDLE: begin
        if (pending_q != 2'b00) begin
          sel_d = grant;
          if (pending_q == 2'b11 && prime[0] == prime[1]) begin
            rr_d = grant;
          end
          if (health[grant]) begin
            pending_d[grant] = 1'b0;
          end else begin
            state_d = ASSERT;
            cnt_d   = '0;
            por_d   = grant ? 2'b10 : 2'b01;
          end
        end
      end
      ASSERT: begin
        if (cnt_q == POR_LAST) begin
          por_d   = 2'b00;
          cnt_d   = '0;
          state_d = WAIT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      WAIT: begin
        if (health[sel_q]) begin
          pending_d[sel_q] = 1'b0;
          retry_d[sel_q]   = 2'd0;
          cnt_d            = '0;
          state_d          = IDLE;
        end else if (cnt_q == WAIT_LAST) begin
          retry_d[sel_q] = retry_next;
          // A lockout that coincides with a clear never takes effect, so the
          // unit stays pending and competes again.
          if (retry_next == MAX_R && !clr_lockout[sel_q]) begin
            lockout_d[sel_q] = 1'b1;
            pending_d[sel_q] = 1'b0;
          end
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        por_d   = 2'b00;
        cnt_d   = '0;
      end
    endcase

    for (int i = 0; i < 2; i++) begin
      if (clr_lockout[i]) begin
        lockout_d[i] = 1'b0;
        retry_d[i]   = 2'd0;
      end
    end

    busy_d = (state_d != IDLE);
  end

  // State and registered outputs; the low-active reset drops por at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      por_q        <= 2'b00;
      lockout_q    <= 2'b00;
      retry_q      <= '0;
      busy_q       <= 1'b0;
      sel_q        <= 1'b0;
      rr_q         <= 1'b0;
      pending_q    <= 2'b00;
      health_dly_q <= 2'b11;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      por_q        <= por_d;
      lockout_q    <= lockout_d;
      retry_q      <= retry_d;
      busy_q       <= busy_d;
      sel_q        <= sel_d;
      rr_q         <= rr_d;
      pending_q    <= pending_d;
      health_dly_q <= health_dly_d;
      cnt_q        <= cnt_d;
    end
  end

  assign por        = por_q;
  assign lockout    = lockout_q;
  assign retry_cnt0 = retry_q[0];
  assign retry_cnt1 = retry_q[1];
  assign busy       = busy_q;
  assign sel        = sel_q;

endmodule

// File: tb/tb_por_sequencer.sv
// tb_por_sequencer: the stimulus side steps a behavioural model of the
// sequencer once per clock. Each predicted output change goes into a queue with
// the cycle where it should appear. A monitor pops an entry whenever the DUT
// outputs change and compares both the value and the cycle.
module tb_por_sequencer;

  localparam int POR_PULSE        = 4;
  localparam int RECOVERY_TIMEOUT = 10;
  localparam int MAX_RETRIES      = 2;
  localparam int CNT_W            = 8;

  logic       clk;
  logic       reset;
  logic [1:0] health;
  logic [1:0] prime;
  logic [1:0] clr_lockout;
  logic [1:0] por;
  logic [1:0] lockout;
  logic [1:0] retry_cnt0;
  logic [1:0] retry_cnt1;
  logic       busy;
  logic       sel;

  int total;
  int bad;
  int cyc;

  logic [9:0] exp_vec[$];
  int         exp_cyc[$];

  // Model state. Service progress is kept as remaining-pulse and
  // waited-cycle counts.
  bit [1:0] m_prev_h, m_pend, m_lock, m_por;
  int       m_retry[2];
  bit       m_busy, m_sel, m_rr;
  int       m_unit, m_pulse_left, m_waited;
  logic [9:0] m_last_vec;

  por_sequencer #(
    .POR_PULSE(POR_PULSE),
    .RECOVERY_TIMEOUT(RECOVERY_TIMEOUT),
    .MAX_RETRIES(MAX_RETRIES),
    .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .reset(reset),
    .health(health),
    .prime(prime),
    .clr_lockout(clr_lockout),
    .por(por),
    .lockout(lockout),
    .retry_cnt0(retry_cnt0),
    .retry_cnt1(retry_cnt1),
    .busy(busy),
    .sel(sel)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [9:0] modelVec();
    logic [1:0] r0, r1;
    r0 = m_retry[0][1:0];
    r1 = m_retry[1][1:0];
    return {m_por, m_lock, r0, r1, m_busy, m_sel};
  endfunction

  task automatic pushIfChanged(input int stamp);
    logic [9:0] v;
    v = modelVec();
    if (v != m_last_vec) begin
      exp_vec.push_back(v);
      exp_cyc.push_back(stamp);
      m_last_vec = v;
    end
  endtask

  task automatic modelReset();
    m_prev_h     = 2'b11;
    m_pend       = 2'b00;
    m_lock       = 2'b00;
    m_por        = 2'b00;
    m_retry[0]   = 0;
    m_retry[1]   = 0;
    m_busy       = 1'b0;
    m_sel        = 1'b0;
    m_rr         = 1'b0;
    m_unit       = 0;
    m_pulse_left = 0;
    m_waited     = 0;
  endtask

  // Advances the model by one clock using the inputs just applied.
  task automatic stepModel();
    bit [1:0] np;
    int g;
    np = m_pend;
    for (int i = 0; i < 2; i++) begin
      if (m_prev_h[i] && !health[i] && !m_lock[i] && !(m_busy && m_unit == i))
        np[i] = 1'b1;
    end
    if (!m_busy) begin
      if (m_pend != 2'b00) begin
        if (m_pend == 2'b01) g = 0;
        else if (m_pend == 2'b10) g = 1;
        else if (prime[0] != prime[1]) g = prime[0] ? 1 : 0;
        else begin
          g = m_rr ? 0 : 1;
          m_rr = (g == 1);
        end
        m_sel = (g == 1);
        if (health[g]) np[g] = 1'b0;
        else begin
          m_busy       = 1'b1;
          m_unit       = g;
          m_pulse_left = POR_PULSE;
        end
      end
    end else if (m_pulse_left > 0) begin
      m_pulse_left--;
      m_waited = 0;
    end else begin
      m_waited++;
      if (health[m_unit]) begin
        np[m_unit]      = 1'b0;
        m_retry[m_unit] = 0;
        m_busy          = 1'b0;
      end else if (m_waited == RECOVERY_TIMEOUT) begin
        if (m_retry[m_unit] < MAX_RETRIES) m_retry[m_unit]++;
        if (m_retry[m_unit] == MAX_RETRIES && !clr_lockout[m_unit]) begin
          m_lock[m_unit] = 1'b1;
          np[m_unit]     = 1'b0;
        end
        m_busy = 1'b0;
      end
    end
    for (int i = 0; i < 2; i++) begin
      if (clr_lockout[i]) begin
        m_lock[i]  = 1'b0;
        m_retry[i] = 0;
      end
    end
    m_pend   = np;
    m_prev_h = health;
    m_por    = 2'b00;
    if (m_busy && m_pulse_left > 0) m_por[m_unit] = 1'b1;
    pushIfChanged(cyc + 1);
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, expected);
    end
  endtask

  // One clock of stimulus: drive at the falling edge, then predict the next
  // rising edge.
  task automatic applyStimulus(input logic [1:0] h, input logic [1:0] p,
                               input logic [1:0] c);
    @(negedge clk);
    health      = h;
    prime       = p;
    clr_lockout = c;
    stepModel();
  endtask

  // Pulls reset low mid-cycle, checks that por drops without a clock edge,
  // holds it for n cycles, and releases it at a falling edge.
  task automatic holdReset(input int n);
    @(negedge clk);
    #1;
    reset       = 1'b0;
    health      = 2'b11;
    clr_lockout = 2'b00;
    modelReset();
    pushIfChanged(cyc + 1);
    #1;
    checkOutput("async_por_drop", {30'd0, por}, 32'd0);
    repeat (n) @(negedge clk);
    reset = 1'b1;
    stepModel();
  endtask

  task automatic idleCycles(input int n, input logic [1:0] h);
    for (int i = 0; i < n; i++) applyStimulus(h, 2'b00, 2'b00);
  endtask

  // Monitor: every change of the DUT outputs must match the next prediction.
  logic [9:0] mon_last = 10'd0;
  always @(negedge clk) begin
    logic [9:0] v;
    v = {por, lockout, retry_cnt0, retry_cnt1, busy, sel};
    if (por != 2'b00) begin
      total++;
      if (por == 2'b11) begin
        bad++;
        $display("[TB] FAIL por_exclusive actual=%b required=not 11", por);
      end
    end
    if (v != mon_last) begin
      total++;
      if (exp_vec.size() == 0) begin
        bad++;
        $display("[TB] FAIL unexpected_change cycle=%0d actual=%b required=no change", cyc, v);
      end else begin
        logic [9:0] ev;
        int ec;
        ev = exp_vec.pop_front();
        ec = exp_cyc.pop_front();
        if (ev != v || ec != cyc) begin
          bad++;
          $display("[TB] FAIL scoreboard cycle=%0d actual=%b required=%b at cycle %0d",
                   cyc, v, ev, ec);
        end
      end
      mon_last = v;
    end
  end

  initial begin
    logic [1:0] h, p, c;
    total       = 0;
    bad         = 0;
    cyc         = 0;
    health      = 2'b11;
    prime       = 2'b00;
    clr_lockout = 2'b00;
    reset       = 1'b1;
    modelReset();
    m_last_vec  = 10'd0;
    #1 reset = 1'b0;

    repeat (3) @(negedge clk);
    #1;
    $display("[TB] checking reset values");
    checkOutput("reset_por", {30'd0, por}, 32'd0);
    checkOutput("reset_lockout", {30'd0, lockout}, 32'd0);
    checkOutput("reset_retry0", {30'd0, retry_cnt0}, 32'd0);
    checkOutput("reset_retry1", {30'd0, retry_cnt1}, 32'd0);
    checkOutput("reset_busy_sel", {30'd0, busy, sel}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    stepModel();

    $display("[TB] unit B drop and recovery");
    idleCycles(2, 2'b11);
    idleCycles(2, 2'b01);
    @(posedge clk); #1;
    checkOutput("b_por_rises", {30'd0, por}, 32'h2);
    idleCycles(POR_PULSE + 2, 2'b01);
    idleCycles(12, 2'b11);
    @(posedge clk); #1;
    checkOutput("b_recovered", {28'd0, lockout, retry_cnt1}, 32'd0);
    checkOutput("b_idle", {31'd0, busy}, 32'd0);

    $display("[TB] both units drop, prime=01");
    for (int i = 0; i < 2 + POR_PULSE + 2; i++) applyStimulus(2'b00, 2'b01, 2'b00);
    for (int i = 0; i < 3; i++) applyStimulus(2'b10, 2'b01, 2'b00);
    @(posedge clk); #1;
    checkOutput("a_served_second", {30'd0, por}, 32'h1);
    for (int i = 0; i < POR_PULSE + 2; i++) applyStimulus(2'b10, 2'b01, 2'b00);
    idleCycles(10, 2'b11);

    $display("[TB] unit A repeated failure");
    idleCycles(2 * (2 + POR_PULSE + RECOVERY_TIMEOUT) + 6, 2'b10);
    @(posedge clk); #1;
    checkOutput("a_lockout", {30'd0, lockout}, 32'h1);
    checkOutput("a_retry_max", {30'd0, retry_cnt0}, MAX_RETRIES);
    idleCycles(2, 2'b11);
    idleCycles(8, 2'b10);
    @(posedge clk); #1;
    checkOutput("locked_no_por", {29'd0, por, busy}, 32'd0);

    $display("[TB] lockout clear");
    applyStimulus(2'b10, 2'b00, 2'b01);
    @(posedge clk); #1;
    checkOutput("clr_lockout", {28'd0, lockout, retry_cnt0}, 32'd0);
    idleCycles(2, 2'b11);
    idleCycles(2, 2'b10);
    @(posedge clk); #1;
    checkOutput("a_por_after_clr", {30'd0, por}, 32'h1);
    idleCycles(POR_PULSE + 2, 2'b10);
    idleCycles(10, 2'b11);

    $display("[TB] self-recovery before grant");
    idleCycles(2 + POR_PULSE + 1, 2'b01);
    idleCycles(2, 2'b00);
    idleCycles(2, 2'b01);
    idleCycles(12, 2'b11);
    @(posedge clk); #1;
    checkOutput("self_recover_idle", {29'd0, por, busy}, 32'd0);

    $display("[TB] reset mid-pulse");
    idleCycles(4, 2'b10);
    holdReset(3);
    @(posedge clk); #1;
    checkOutput("post_reset_outputs",
                {22'd0, por, lockout, retry_cnt0, retry_cnt1, busy, sel}, 32'd0);

    $display("[TB] randomized traffic");
    h = 2'b11;
    p = 2'b00;
    for (int n = 0; n < 2500; n++) begin
      if ($urandom_range(0, 599) == 0) begin
        holdReset($urandom_range(1, 3));
        h = 2'b11;
      end else begin
        if ($urandom_range(0, 11) == 0) h[$urandom_range(0, 1)] ^= 1'b1;
        if ($urandom_range(0, 19) == 0) begin
          case ($urandom_range(0, 2))
            0:       p = 2'b00;
            1:       p = 2'b01;
            default: p = 2'b10;
          endcase
        end
        c = 2'b00;
        if ($urandom_range(0, 39) == 0) c = 2'($urandom_range(1, 3));
        applyStimulus(h, p, c);
      end
    end

    idleCycles(RECOVERY_TIMEOUT * 3 + POR_PULSE * 3, 2'b11);
    @(negedge clk); #1;
    checkOutput("scoreboard_drained", exp_vec.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
